// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment scan path:
// state encoding, digit count and anode-off polarity helper.
package display_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_BLANK = BLANK,
    S_SHOW  = SHOW
  } state_e;

  function automatic logic [NUM_DIGITS-1:0] ANODE_OFF(input bit active_low);
    return active_low ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// Modulo-SCAN_DIV slot counter with synchronous clear; flags the last
// blanking cycle and the last cycle of the slot.
module scan_slot_counter #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic blank_tc_o,
  output logic slot_tc_o
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign blank_tc_o = (count_q == CW'(BLANK_CYCLES - 1));
  assign slot_tc_o  = (count_q == CW'(SCAN_DIV - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (clr_i || slot_tc_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit display scan controller: walks SEL through the digits, blanks
// all anodes at the start of every slot and pulses FRAME once per full scan.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [3:0] DIGIT_EN,
  output logic [1:0] SEL,
  output logic [3:0] ANODE,
  output logic       BLANK,
  output logic       FRAME,
  output logic [1:0] DBG_STATE
);

  import display_pkg::*;

  localparam logic [NUM_DIGITS-1:0] OFF = ANODE_OFF(ACTIVE_LOW != 0);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [3:0] anode_q;
  logic       blank_q;
  logic       frame_q;
  logic       clr;
  logic       blank_tc;
  logic       slot_tc;

  // The counter is held at zero in IDLE so the first BLANK cycle sees count 0.
  assign clr = !ENABLE || (state_q == S_IDLE);

  scan_slot_counter #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_counter (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .clr_i     (clr),
    .blank_tc_o(blank_tc),
    .slot_tc_o (slot_tc)
  );

  function automatic logic [NUM_DIGITS-1:0] anode_on(input logic [1:0] sel,
                                                     input logic [3:0] mask);
    logic [NUM_DIGITS-1:0] oh;
    oh = mask[sel] ? (NUM_DIGITS'(1) << sel) : '0;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      anode_q <= OFF;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (!ENABLE) begin
        state_q <= S_IDLE;
        sel_q   <= 2'd0;
        anode_q <= OFF;
        blank_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_BLANK;
            anode_q <= OFF;
            blank_q <= 1'b1;
          end
          S_BLANK: begin
            if (blank_tc) begin
              state_q <= S_SHOW;
              anode_q <= anode_on(sel_q, DIGIT_EN);
              blank_q <= 1'b0;
            end else begin
              anode_q <= OFF;
              blank_q <= 1'b1;
            end
          end
          S_SHOW: begin
            if (slot_tc) begin
              // SEL advances on the same edge the anodes go dark.
              state_q <= S_BLANK;
              sel_q   <= sel_q + 2'd1;
              anode_q <= OFF;
              blank_q <= 1'b1;
              frame_q <= (sel_q == 2'd3);
            end else begin
              anode_q <= anode_on(sel_q, DIGIT_EN);
              blank_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            anode_q <= OFF;
            blank_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign SEL       = sel_q;
  assign ANODE     = anode_q;
  assign BLANK     = blank_q;
  assign FRAME     = frame_q;
  assign DBG_STATE = state_q;

endmodule
